// File: rtl/hinf_fixed_pkg.sv
// Shared fixed-point definitions for the filter datapath (Q28.35, 64-bit words).
// Holds the word geometry, the common Q-format constants used by the 3x3
// inverter and multiplier, and the matmul FSM state type.
package hinf_fixed_pkg;

  localparam int unsigned WIDTH     = 64;
  localparam int unsigned FRAC_BITS = 35;

  localparam logic signed [WIDTH-1:0] Q_ONE = 64'sh0000_0008_0000_0000;
  localparam logic signed [WIDTH-1:0] Q_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [WIDTH-1:0] Q_MIN = 64'sh8000_0000_0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } matmul_state_e;

endpackage

// File: rtl/matmul3x3_if.sv
// Request/operand/result bundle for matmul3x3. The master side issues start and
// operands; the slave side (the multiplier) returns the product and status.
interface matmul3x3_if ();
  import hinf_fixed_pkg::*;

  logic                    start;
  logic signed [WIDTH-1:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
  logic signed [WIDTH-1:0] B00, B01, B02, B10, B11, B12, B20, B21, B22;
  logic signed [WIDTH-1:0] C00, C01, C02, C10, C11, C12, C20, C21, C22;
  logic                    busy;
  logic                    done;
  logic                    ovf;

  modport master (
    output start,
    output A00, A01, A02, A10, A11, A12, A20, A21, A22,
    output B00, B01, B02, B10, B11, B12, B20, B21, B22,
    input  C00, C01, C02, C10, C11, C12, C20, C21, C22,
    input  busy, done, ovf
  );

  modport slave (
    input  start,
    input  A00, A01, A02, A10, A11, A12, A20, A21, A22,
    input  B00, B01, B02, B10, B11, B12, B20, B21, B22,
    output C00, C01, C02, C10, C11, C12, C20, C21, C22,
    output busy, done, ovf
  );

endinterface

// File: rtl/mac_q35.sv
// Time-shared Q28.35 multiply-accumulate. Accumulates full-precision products in
// a 2*WIDTH+2 bit register; on the final term it shifts back to Q28.35 and
// range-checks. MATMUL_SAT_EN selects clamping of out-of-range results;
// otherwise the low WIDTH bits are kept (wrap).
module mac_q35 import hinf_fixed_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result,
  output logic                    out_of_range
);

  localparam int unsigned AccW = 2 * WIDTH + 2;

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic signed [AccW-1:0]    acc_q, acc_d, sum, shifted;
  logic [AccW-WIDTH:0]       top_bits;

  // Product, running sum, and the rescaled/range-checked element value.
  always_comb begin
    a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext    = {{WIDTH{b[WIDTH-1]}}, b};
    prod     = a_ext * b_ext;
    sum      = acc_q + {{2{prod[2*WIDTH-1]}}, prod};
    shifted  = sum >>> FRAC_BITS;
    // In range only if every bit from the WIDTH-1 sign position upward agrees.
    top_bits = shifted[AccW-1:WIDTH-1];
    out_of_range = !((&top_bits) || !(|top_bits));
`ifdef MATMUL_SAT_EN
    if (out_of_range) begin
      result = shifted[AccW-1] ? Q_MIN : Q_MAX;
    end else begin
      result = shifted[WIDTH-1:0];
    end
`else
    result = shifted[WIDTH-1:0];
`endif
  end

  // Accumulator next state: cleared on request and after each element's last term.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = last ? '0 : sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matmul3x3.sv
// Sequential 3x3 Q28.35 matrix multiplier C = A*B using one shared MAC.
// 27 MAC cycles (k innermost, then j, then i), then one DONE cycle. The output
// registers load all nine elements at once, so C never shows partial results.
// Saturation of out-of-range elements is enabled by defining MATMUL_SAT_EN.
module matmul3x3 import hinf_fixed_pkg::*; (
  input logic        clk,
  input logic        rst,
  matmul3x3_if.slave bus
);

  matmul_state_e state_q, state_d;
  logic [1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [3:0] a_idx, b_idx, c_idx;
  logic capture, mac_en, mac_clear, last_k, last_elem;
  logic ovf_sticky_q, ovf_q, elem_oor;
  logic signed [WIDTH-1:0] mac_result;
  logic signed [WIDTH-1:0] a_in [9];
  logic signed [WIDTH-1:0] b_in [9];
  logic signed [WIDTH-1:0] a_cap_q [9];
  logic signed [WIDTH-1:0] b_cap_q [9];
  logic signed [WIDTH-1:0] cbuf_q [9];
  logic signed [WIDTH-1:0] c_q [9];

  assign a_in[0] = bus.A00;  assign a_in[1] = bus.A01;  assign a_in[2] = bus.A02;
  assign a_in[3] = bus.A10;  assign a_in[4] = bus.A11;  assign a_in[5] = bus.A12;
  assign a_in[6] = bus.A20;  assign a_in[7] = bus.A21;  assign a_in[8] = bus.A22;
  assign b_in[0] = bus.B00;  assign b_in[1] = bus.B01;  assign b_in[2] = bus.B02;
  assign b_in[3] = bus.B10;  assign b_in[4] = bus.B11;  assign b_in[5] = bus.B12;
  assign b_in[6] = bus.B20;  assign b_in[7] = bus.B21;  assign b_in[8] = bus.B22;
  assign bus.C00 = c_q[0];   assign bus.C01 = c_q[1];   assign bus.C02 = c_q[2];
  assign bus.C10 = c_q[3];   assign bus.C11 = c_q[4];   assign bus.C12 = c_q[5];
  assign bus.C20 = c_q[6];   assign bus.C21 = c_q[7];   assign bus.C22 = c_q[8];

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.ovf  = ovf_q;

  assign a_idx     = 4'(i_q) * 4'd3 + 4'(k_q);
  assign b_idx     = 4'(k_q) * 4'd3 + 4'(j_q);
  assign c_idx     = 4'(i_q) * 4'd3 + 4'(j_q);
  assign last_k    = (k_q == 2'd2);
  assign last_elem = mac_en && last_k && (i_q == 2'd2) && (j_q == 2'd2);

  mac_q35 u_mac (
    .clk          (clk),
    .rst          (rst),
    .clear        (mac_clear),
    .en           (mac_en),
    .last         (last_k),
    .a            (a_cap_q[a_idx]),
    .b            (b_cap_q[b_idx]),
    .result       (mac_result),
    .out_of_range (elem_oor)
  );

  // FSM next state, index stepping and datapath strobes.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    capture   = 1'b0;
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          capture   = 1'b1;
          mac_clear = 1'b1;
          i_d       = 2'd0;
          j_d       = 2'd0;
          k_d       = 2'd0;
          state_d   = StRun;
        end
      end
      StRun: begin
        mac_en = 1'b1;
        if (!last_k) begin
          k_d = k_q + 2'd1;
        end else begin
          k_d = 2'd0;
          if (j_q != 2'd2) begin
            j_d = j_q + 2'd1;
          end else begin
            j_d = 2'd0;
            if (i_q != 2'd2) begin
              i_d = i_q + 2'd1;
            end else begin
              i_d     = 2'd0;
              state_d = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Operand capture on accepted start; inputs are free to change afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) begin
        a_cap_q[n] <= '0;
        b_cap_q[n] <= '0;
      end
    end else if (capture) begin
      for (int n = 0; n < 9; n++) begin
        a_cap_q[n] <= a_in[n];
        b_cap_q[n] <= b_in[n];
      end
    end
  end

  // Element buffer and sticky overflow, written on each element's last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) cbuf_q[n] <= '0;
      ovf_sticky_q <= 1'b0;
    end else if (capture) begin
      ovf_sticky_q <= 1'b0;
    end else if (mac_en && last_k) begin
      cbuf_q[c_idx] <= mac_result;
      ovf_sticky_q  <= ovf_sticky_q | elem_oor;
    end
  end

  // Output registers load together; the final element bypasses cbuf so C is
  // already valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) c_q[n] <= '0;
      ovf_q <= 1'b0;
    end else if (last_elem) begin
      for (int n = 0; n < 9; n++) c_q[n] <= (n == 8) ? mac_result : cbuf_q[n];
      ovf_q <= ovf_sticky_q | elem_oor;
    end
  end

endmodule
